// File: rtl/stack_arbiter_if.sv
// Bundle of signals around the stack arbiter: two requester ports, the
// strobes and data to and from the shared LIFO, and the occupancy flags.
// The slave modport is the arbiter's view. The master modport is everything
// around it: the requesters and the LIFO.
interface stack_arbiter_if #(
    parameter int WL = 6
);
    logic          req0;
    logic          req1;
    logic          op0;
    logic          op1;
    logic [WL-1:0] din0;
    logic [WL-1:0] din1;
    logic          gnt0;
    logic          gnt1;
    logic          done0;
    logic          done1;
    logic          err0;
    logic          err1;
    logic [WL-1:0] dout;
    logic          stk_push;
    logic          stk_pop;
    logic [WL-1:0] stk_din;
    logic [WL-1:0] stk_q;
    logic          full;
    logic          empty;

    modport master (
        output req0, req1, op0, op1, din0, din1, stk_q,
        input  gnt0, gnt1, done0, done1, err0, err1, dout,
               stk_push, stk_pop, stk_din, full, empty
    );

    modport slave (
        input  req0, req1, op0, op1, din0, din1, stk_q,
        output gnt0, gnt1, done0, done1, err0, err1, dout,
               stk_push, stk_pop, stk_din, full, empty
    );
endinterface

// File: rtl/stack_arbiter.sv
// Two-requester arbiter in front of a shared external LIFO.
// Each operation takes three cycles:
//   IDLE  : arbitrate
//   ISSUE : grant the winner and strobe the LIFO
//   RESP  : done pulse, plus pop data or an error
// Pushes to a full stack and pops from an empty stack complete with err set
// and never touch the LIFO.
// Build option: define STACK_ARB_RR_EN for round-robin tie-breaking.
// Without it, requester 0 has fixed priority.
module stack_arbiter #(
    parameter int WL = 6,
    parameter int N  = 3
) (
    input  logic           clk,
    input  logic           reset,
    stack_arbiter_if.slave bus
);
    localparam logic [N-1:0] DEPTH = {N{1'b1}};

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]    state_reg;
    logic [1:0]    state_next;
    logic          id_reg;
    logic          op_reg;
    logic [WL-1:0] din_reg;
    logic          err_reg;
    logic [N-1:0]  cnt_reg;
    logic [N-1:0]  cnt_next;
    logic          full_reg;
    logic          empty_reg;

    logic [1:0]    req_vec;
    logic          any_req;
    logic          win;
    logic          win_op;
    logic [WL-1:0] win_din;
    logic          illegal;
    logic          in_issue;
    logic          in_resp;
    logic          legal_issue;
    logic [1:0]    gnt_vec;
    logic [1:0]    done_vec;
    logic [1:0]    err_vec;

    assign req_vec = {bus.req1, bus.req0};
    assign any_req = |req_vec;

`ifdef STACK_ARB_RR_EN
    logic last_reg;

    // Round-robin: on a tie, the requester not served last wins.
    always_comb begin
        win = 1'b0;
        if (&req_vec) begin
            win = ~last_reg;
        end else begin
            win = ~req_vec[0];
        end
    end

    // Remember who was granted last. Reset points at requester 1, so
    // requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_reg <= 1'b1;
        end else if (state_reg == IDLE && any_req) begin
            last_reg <= win;
        end
    end
`else
    // Fixed priority: requester 0 wins whenever it is requesting.
    always_comb begin
        win = ~req_vec[0];
    end
`endif

    assign win_op  = win ? bus.op1 : bus.op0;
    assign win_din = win ? bus.din1 : bus.din0;

    // Legality is decided at arbitration time. The count cannot change
    // between IDLE and ISSUE, so this is the same answer ISSUE would get.
    assign illegal = win_op ? (cnt_reg == DEPTH) : (cnt_reg == '0);

    // Next state: IDLE -> ISSUE -> RESP -> IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = any_req ? ISSUE : IDLE;
            ISSUE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register plus the winner's latched id, op, data and error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            id_reg    <= 1'b0;
            op_reg    <= 1'b0;
            din_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && any_req) begin
                id_reg  <= win;
                op_reg  <= win_op;
                din_reg <= win_din;
                err_reg <= illegal;
            end
        end
    end

    assign in_issue    = (state_reg == ISSUE);
    assign in_resp     = (state_reg == RESP);
    assign legal_issue = in_issue && !err_reg;

    // The occupancy count moves only on a legal ISSUE, so it never wraps.
    always_comb begin
        cnt_next = cnt_reg;
        if (legal_issue) begin
            cnt_next = op_reg ? cnt_reg + 1'b1 : cnt_reg - 1'b1;
        end
    end

    // Count register and the registered full/empty flags derived from it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg   <= '0;
            full_reg  <= 1'b0;
            empty_reg <= 1'b1;
        end else begin
            cnt_reg   <= cnt_next;
            full_reg  <= (cnt_next == DEPTH);
            empty_reg <= (cnt_next == '0);
        end
    end

    // Per-requester grant, done and error decode.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign gnt_vec[gi]  = in_issue && (id_reg == 1'(gi));
            assign done_vec[gi] = in_resp && (id_reg == 1'(gi));
            assign err_vec[gi]  = done_vec[gi] && err_reg;
        end
    endgenerate

    assign bus.gnt0  = gnt_vec[0];
    assign bus.gnt1  = gnt_vec[1];
    assign bus.done0 = done_vec[0];
    assign bus.done1 = done_vec[1];
    assign bus.err0  = err_vec[0];
    assign bus.err1  = err_vec[1];

    // Push and pop strobes are mutually exclusive because op_reg is a
    // single bit.
    assign bus.stk_push = legal_issue && op_reg;
    assign bus.stk_pop  = legal_issue && !op_reg;
    assign bus.stk_din  = (in_issue && op_reg) ? din_reg : '0;

    // The LIFO presents popped data in the cycle after the strobe, which is
    // RESP, so the data is passed through only while the pop is completing.
    assign bus.dout  = (in_resp && !op_reg && !err_reg) ? bus.stk_q : '0;
    assign bus.full  = full_reg;
    assign bus.empty = empty_reg;
endmodule
